// File: rtl/sram_ecc_pkg.sv
// Shared constants and code layout for the SRAM page ECC encoder and its decoder.
package sram_ecc_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned PAGE_WORDS = 8;
  localparam int unsigned CODE_W     = 8;
  localparam int unsigned IDX_W      = $clog2(PAGE_WORDS);
  localparam int unsigned ACC_W      = CODE_W - 1;
  localparam int unsigned LO_W       = ACC_W - IDX_W;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [ACC_W-1:0]  acc_t;

  // code[6:0] = position-weighted parity, code[7] = bit 15 of the last word
  typedef struct packed {
    logic msb;
    acc_t parity;
  } code_t;

  localparam idx_t LAST_IDX = IDX_W'(PAGE_WORDS - 1);

endpackage

// File: rtl/ecc_word_contrib.sv
// Combinational parity contribution of one page word to the running accumulator.
module ecc_word_contrib
  import sram_ecc_pkg::*;
(
  input  word_t data,
  input  idx_t  batch,
  output acc_t  contrib_c
);

  logic [LO_W-1:0]  lo;
  logic [IDX_W-1:0] hi;

  // Bits 0..14 sit at j = 16w + b + 1; bit 15 wraps into the next word's high index.
  always_comb begin
    lo = '0;
    hi = '0;
    for (int b = 0; b < int'(WORD_W) - 1; b++) begin
      if (data[b]) lo = lo ^ LO_W'(b + 1);
    end
    if (^data[WORD_W-2:0]) hi = hi ^ batch;
    if (data[WORD_W-1])    hi = hi ^ (batch + IDX_W'(1));
    contrib_c = {hi, lo};
  end

endmodule

// File: rtl/sram_ecc_encoder.sv
// Streaming page ECC encoder: passes words through with one cycle of latency and
// emits the page code after an in-order word 7.
module sram_ecc_encoder
  import sram_ecc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  in_batch,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_batch,
  output logic [WORD_W-1:0] out_data,
  output logic              end_of_page,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              seq_err
);

  logic  out_valid_q, out_valid_d;
  idx_t  out_batch_q, out_batch_d;
  word_t out_data_q,  out_data_d;
  logic  eop_q,       eop_d;
  code_t code_q,      code_d;
  logic  code_vld_q,  code_vld_d;
  logic  seq_err_q,   seq_err_d;
  acc_t  acc_q,       acc_d;
  idx_t  exp_q,       exp_d;

  acc_t  contrib;
  acc_t  acc_next;

  ecc_word_contrib u_contrib (
    .data      (in_data),
    .batch     (in_batch),
    .contrib_c (contrib)
  );

  assign acc_next = ((exp_q == '0) ? '0 : acc_q) ^ contrib;

  always_comb begin
    out_valid_d = in_valid;
    out_batch_d = in_batch;
    out_data_d  = in_data;
    eop_d       = 1'b0;
    code_d      = code_q;
    code_vld_d  = 1'b0;
    seq_err_d   = 1'b0;
    acc_d       = acc_q;
    exp_d       = exp_q;
    if (in_valid) begin
      if (in_batch == exp_q) begin
        exp_d = exp_q + IDX_W'(1);
        if (in_batch == LAST_IDX) begin
          code_d     = '{msb: in_data[WORD_W-1], parity: acc_next};
          code_vld_d = 1'b1;
          eop_d      = 1'b1;
          acc_d      = '0;
        end else begin
          acc_d = acc_next;
        end
      end else begin
        // A stray word 0 is treated as the start of a fresh page.
        seq_err_d = 1'b1;
        if (in_batch == '0) begin
          acc_d = contrib;
          exp_d = IDX_W'(1);
        end else begin
          acc_d = '0;
          exp_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_batch_q <= '0;
      out_data_q  <= '0;
      eop_q       <= 1'b0;
      code_q      <= '0;
      code_vld_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      acc_q       <= '0;
      exp_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_batch_q <= out_batch_d;
      out_data_q  <= out_data_d;
      eop_q       <= eop_d;
      code_q      <= code_d;
      code_vld_q  <= code_vld_d;
      seq_err_q   <= seq_err_d;
      acc_q       <= acc_d;
      exp_q       <= exp_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_batch   = out_batch_q;
  assign out_data    = out_data_q;
  assign end_of_page = eop_q;
  assign code        = code_q;
  assign code_valid  = code_vld_q;
  assign seq_err     = seq_err_q;

endmodule
